// File: rtl/seq_add128_pkg.sv
// rtl/seq_add128_pkg.sv - shared constants and FSM state type for the two-pass 128-bit adder
package seq_add128_pkg;

    localparam int HALF_W = 64;
    localparam int FULL_W = 2 * HALF_W;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/seq_add128_if.sv
// rtl/seq_add128_if.sv - operand/result handshake bundle for seq_add128
interface seq_add128_if;
    import seq_add128_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [FULL_W-1:0] a;
    logic [FULL_W-1:0] b;
    logic              cin;
    logic              out_valid;
    logic              out_ready;
    logic [FULL_W-1:0] sum;
    logic              cout;
    logic [CNT_W-1:0]  done_cnt;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, done_cnt
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, done_cnt
    );

endinterface

// File: rtl/seq_add128_csa.sv
// rtl/seq_add128_csa.sv - combinational 64-bit carry-select adder built from 16-bit blocks
module Con_sa_16_bit_block_64 (
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  logic        cin_i,
    output logic [63:0] sum_o,
    output logic        cout_o
);

    logic [16:0] blk0_sum;
    logic [16:0] blk1_sum;
    logic        carry;

    // Each block precomputes carry-in 0 and 1 results; the ripple of block carries picks one.
    always_comb begin
        sum_o    = '0;
        blk0_sum = '0;
        blk1_sum = '0;
        carry    = cin_i;
        for (int k = 0; k < 4; k++) begin
            blk0_sum = {1'b0, a_i[16*k +: 16]} + {1'b0, b_i[16*k +: 16]};
            blk1_sum = blk0_sum + 17'd1;
            sum_o[16*k +: 16] = carry ? blk1_sum[15:0] : blk0_sum[15:0];
            carry = carry ? blk1_sum[16] : blk0_sum[16];
        end
        cout_o = carry;
    end

endmodule

// File: rtl/seq_add128.sv
// rtl/seq_add128.sv - two-pass 128-bit adder sharing one 64-bit carry-select adder
module seq_add128 #(
    parameter int HALF_W = 64
) (
    input  logic       clk,
    input  logic       rst,
    seq_add128_if.slave bus
);
    import seq_add128_pkg::*;

    generate
        if (HALF_W != seq_add128_pkg::HALF_W) begin : g_bad_half_w
            $error("seq_add128: only HALF_W=64 is supported");
        end
    endgenerate

    state_e            state_q;
    logic [FULL_W-1:0] a_q;
    logic [FULL_W-1:0] b_q;
    logic              cin_q;
    logic              carry_q;
    logic [FULL_W-1:0] sum_q;
    logic              cout_q;
    logic              out_valid_q;
    logic [CNT_W-1:0]  done_cnt_q;
    logic [CNT_W-1:0]  done_cnt_d;

    logic [HALF_W-1:0] add_a;
    logic [HALF_W-1:0] add_b;
    logic              add_cin;
    logic [HALF_W-1:0] add_sum;
    logic              add_cout;
    logic              in_ready;
    logic              out_hs;

    // Operand mux: the high pass reuses the adder with the carry saved from the low pass.
    always_comb begin
        add_a   = a_q[HALF_W-1:0];
        add_b   = b_q[HALF_W-1:0];
        add_cin = cin_q;
        if (state_q == HIGH) begin
            add_a   = a_q[FULL_W-1:HALF_W];
            add_b   = b_q[FULL_W-1:HALF_W];
            add_cin = carry_q;
        end
    end

    Con_sa_16_bit_block_64 u_csa (
        .a_i    (add_a),
        .b_i    (add_b),
        .cin_i  (add_cin),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign out_hs   = out_valid_q && bus.out_ready;

    // Sequencer: capture operands, run low then high pass, hold result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        cin_q   <= bus.cin;
                        state_q <= LOW;
                    end
                end
                LOW: begin
                    sum_q[HALF_W-1:0] <= add_sum;
                    carry_q           <= add_cout;
                    state_q           <= HIGH;
                end
                HIGH: begin
                    sum_q[FULL_W-1:HALF_W] <= add_sum;
                    cout_q                 <= add_cout;
                    out_valid_q            <= 1'b1;
                    state_q                <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (bus.in_valid) begin
                            a_q     <= bus.a;
                            b_q     <= bus.b;
                            cin_q   <= bus.cin;
                            state_q <= LOW;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Completed-handshake count; free-running wrap at 16 bits.
    always_comb begin
        done_cnt_d = done_cnt_q + {{(CNT_W-1){1'b0}}, out_hs};
    end

    // Counter register, reloaded every cycle from its next-state value.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_cnt_q <= '0;
        end else begin
            done_cnt_q <= done_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_seq_add128.sv
// tb/tb_seq_add128.sv - scoreboard bench for seq_add128
module tb_seq_add128;
    import seq_add128_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_add128_if bus_if ();

    seq_add128 #(.HALF_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct packed {
        logic [127:0] sum;
        logic         cout;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_cnt  = 16'h0000;

    function automatic exp_t model(input logic [127:0] a, input logic [127:0] b, input logic cin);
        logic [128:0] t;
        exp_t e;
        t = {1'b0, a} + {1'b0, b} + {128'd0, cin};
        e.sum  = t[127:0];
        e.cout = t[128];
        return e;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        bus_if.a = '0; bus_if.b = '0; bus_if.cin = 1'b0;
        step; step;
        checks++; if (bus_if.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", bus_if.in_ready); end
        checks++; if (bus_if.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", bus_if.out_valid); end
        checks++; if (bus_if.sum !== 128'd0) begin failures++; $display("FAIL reset_sum: got %h expected 0", bus_if.sum); end
        checks++; if (bus_if.cout !== 1'b0) begin failures++; $display("FAIL reset_cout: got %b expected 0", bus_if.cout); end
        checks++; if (bus_if.done_cnt !== 16'h0000) begin failures++; $display("FAIL reset_done_cnt: got %h expected 0000", bus_if.done_cnt); end
        rst = 1'b0;
        exp_cnt = 16'h0000;
    endtask

    task automatic test_txn(input logic [127:0] a, input logic [127:0] b, input logic cin, input string name);
        exp_t e;
        int   edges;
        exp_q.push_back(model(a, b, cin));
        bus_if.a = a; bus_if.b = b; bus_if.cin = cin;
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = 1'b0;
        #1;
        checks++; if (bus_if.in_ready !== 1'b1) begin failures++; $display("FAIL %s_accept_ready: got %b expected 1", name, bus_if.in_ready); end
        step;
        bus_if.in_valid = 1'b0;
        edges = 1;
        while (bus_if.out_valid !== 1'b1 && edges < 12) begin
            step;
            edges++;
        end
        checks++; if (edges != 3) begin failures++; $display("FAIL %s_latency: got %0d edges expected 3", name, edges); end
        e = exp_q.pop_front();
        checks++; if (bus_if.sum !== e.sum) begin failures++; $display("FAIL %s_sum: got %h expected %h", name, bus_if.sum, e.sum); end
        checks++; if (bus_if.cout !== e.cout) begin failures++; $display("FAIL %s_cout: got %b expected %b", name, bus_if.cout, e.cout); end
        bus_if.out_ready = 1'b1;
        #1;
        checks++; if (bus_if.in_ready !== 1'b1) begin failures++; $display("FAIL %s_done_ready: got %b expected 1", name, bus_if.in_ready); end
        step;
        bus_if.out_ready = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        checks++; if (bus_if.done_cnt !== exp_cnt) begin failures++; $display("FAIL %s_done_cnt: got %h expected %h", name, bus_if.done_cnt, exp_cnt); end
        checks++; if (bus_if.out_valid !== 1'b0) begin failures++; $display("FAIL %s_out_valid_drop: got %b expected 0", name, bus_if.out_valid); end
    endtask

    task automatic test_reset_mid;
        bus_if.a = 128'd5; bus_if.b = 128'd6; bus_if.cin = 1'b0;
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = 1'b1;
        step;
        bus_if.in_valid = 1'b0;
        step;
        checks++; if (bus_if.sum[63:0] !== 64'd11) begin failures++; $display("FAIL mid_low_pass: got %h expected b", bus_if.sum[63:0]); end
        rst = 1'b1;
        step;
        rst = 1'b0;
        checks++; if (bus_if.out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid: got %b expected 0", bus_if.out_valid); end
        checks++; if (bus_if.sum !== 128'd0) begin failures++; $display("FAIL mid_sum: got %h expected 0", bus_if.sum); end
        checks++; if (bus_if.in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready: got %b expected 1", bus_if.in_ready); end
        for (int i = 0; i < 4; i++) begin
            step;
            checks++; if (bus_if.out_valid !== 1'b0) begin failures++; $display("FAIL mid_discard_%0d: got %b expected 0", i, bus_if.out_valid); end
        end
        checks++; if (bus_if.done_cnt !== 16'h0000) begin failures++; $display("FAIL mid_done_cnt: got %h expected 0000", bus_if.done_cnt); end
        bus_if.out_ready = 1'b0;
    endtask

    task automatic test_hold;
        logic [127:0] a, b, a2;
        exp_t e;
        int   edges;
        a  = {$urandom, $urandom, $urandom, $urandom};
        b  = {$urandom, $urandom, $urandom, $urandom};
        a2 = ~a;
        exp_q.push_back(model(a, b, 1'b1));
        bus_if.a = a; bus_if.b = b; bus_if.cin = 1'b1;
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = 1'b0;
        step;
        bus_if.a = a2; bus_if.b = 128'd1; bus_if.cin = 1'b0;
        edges = 1;
        while (bus_if.out_valid !== 1'b1 && edges < 12) begin
            step;
            edges++;
        end
        checks++; if (edges != 3) begin failures++; $display("FAIL hold_latency: got %0d edges expected 3", edges); end
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus_if.sum !== e.sum) begin failures++; $display("FAIL hold_sum_%0d: got %h expected %h", i, bus_if.sum, e.sum); end
            checks++; if (bus_if.in_ready !== 1'b0) begin failures++; $display("FAIL hold_in_ready_%0d: got %b expected 0", i, bus_if.in_ready); end
            checks++; if (bus_if.out_valid !== 1'b1) begin failures++; $display("FAIL hold_out_valid_%0d: got %b expected 1", i, bus_if.out_valid); end
            step;
        end
        checks++; if (dut.a_q !== a) begin failures++; $display("FAIL hold_no_capture: got %h expected %h", dut.a_q, a); end
        checks++; if (bus_if.cout !== e.cout) begin failures++; $display("FAIL hold_cout: got %b expected %b", bus_if.cout, e.cout); end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        step;
        bus_if.out_ready = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        checks++; if (bus_if.done_cnt !== exp_cnt) begin failures++; $display("FAIL hold_done_cnt: got %h expected %h", bus_if.done_cnt, exp_cnt); end
        checks++; if (bus_if.out_valid !== 1'b0) begin failures++; $display("FAIL hold_release: got %b expected 0", bus_if.out_valid); end
    endtask

    task automatic test_back_to_back;
        logic [127:0] a_list [2];
        logic [127:0] b_list [2];
        int   out_cyc [2];
        int   n_out, idx, in_cyc0;
        logic in_hs, out_hs;
        exp_t e;
        a_list[0] = 128'd1; b_list[0] = 128'd2;
        a_list[1] = 128'd3; b_list[1] = 128'd4;
        n_out = 0; idx = 0; in_cyc0 = -1;
        out_cyc[0] = 0; out_cyc[1] = 0;
        bus_if.out_ready = 1'b1;
        bus_if.in_valid  = 1'b1;
        bus_if.a = a_list[0]; bus_if.b = b_list[0]; bus_if.cin = 1'b0;
        exp_q.push_back(model(a_list[0], b_list[0], 1'b0));
        for (int cyc = 0; cyc < 20 && n_out < 2; cyc++) begin
            #1;
            in_hs  = bus_if.in_valid && bus_if.in_ready;
            out_hs = bus_if.out_valid && bus_if.out_ready;
            if (out_hs) begin
                e = exp_q.pop_front();
                checks++; if (bus_if.sum !== e.sum) begin failures++; $display("FAIL b2b_sum_%0d: got %h expected %h", n_out, bus_if.sum, e.sum); end
                checks++; if (bus_if.cout !== e.cout) begin failures++; $display("FAIL b2b_cout_%0d: got %b expected %b", n_out, bus_if.cout, e.cout); end
                out_cyc[n_out] = cyc;
                n_out++;
            end
            if (in_hs && in_cyc0 < 0) in_cyc0 = cyc;
            step;
            if (in_hs) begin
                idx++;
                if (idx < 2) begin
                    bus_if.a = a_list[idx]; bus_if.b = b_list[idx];
                    exp_q.push_back(model(a_list[idx], b_list[idx], 1'b0));
                end else begin
                    bus_if.in_valid = 1'b0;
                end
            end
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        checks++; if (n_out != 2) begin failures++; $display("FAIL b2b_count: got %0d results expected 2", n_out); end
        checks++; if (out_cyc[0] - in_cyc0 != 3) begin failures++; $display("FAIL b2b_first_latency: got %0d expected 3", out_cyc[0] - in_cyc0); end
        checks++; if (out_cyc[1] - out_cyc[0] != 3) begin failures++; $display("FAIL b2b_spacing: got %0d expected 3", out_cyc[1] - out_cyc[0]); end
        exp_cnt = exp_cnt + 16'd2;
        checks++; if (bus_if.done_cnt !== exp_cnt) begin failures++; $display("FAIL b2b_done_cnt: got %h expected %h", bus_if.done_cnt, exp_cnt); end
    endtask

    task automatic test_wrap;
        @(negedge clk);
        force dut.done_cnt_q = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.done_cnt_q;
        #1;
        exp_cnt = 16'hFFFE;
        checks++; if (bus_if.done_cnt !== 16'hFFFE) begin failures++; $display("FAIL wrap_preload: got %h expected fffe", bus_if.done_cnt); end
        test_txn(128'd10, 128'd20, 1'b0, "wrap_a");
        test_txn(128'd30, 128'd40, 1'b1, "wrap_b");
        checks++; if (bus_if.done_cnt !== 16'h0000) begin failures++; $display("FAIL wrap_zero: got %h expected 0000", bus_if.done_cnt); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_reset_mid;
        test_txn(128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, "low_carry");
        test_txn({128{1'b1}}, {128{1'b1}}, 1'b1, "all_ones");
        test_txn(128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'd0, 1'b1, "cin_ripple");
        for (int i = 0; i < 3; i++) begin
            test_txn({$urandom, $urandom, $urandom, $urandom},
                     {$urandom, $urandom, $urandom, $urandom},
                     1'($urandom_range(0, 1)), "random");
        end
        test_hold;
        test_back_to_back;
        test_wrap;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
